// File: rtl/alu_issue_sequencer_if.sv
// Handshake and datapath bundle between the ALU issue sequencer and its environment
// (fetch/decode, register file, ALU).
interface alu_issue_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    logic [4:0]  rf_rd_addr1;
    logic [4:0]  rf_rd_addr2;
    logic [31:0] rf_rd_data1;
    logic [31:0] rf_rd_data2;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [2:0]  alu_control;
    logic        alu_select;
    logic [31:0] alu_res;
    logic [2:0]  alu_flags;

    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    logic        br_taken;
    logic [15:0] br_offset;
    logic        done;
    logic        illegal;

    modport master (
        input  instr_valid, instr, rf_rd_data1, rf_rd_data2, alu_res, alu_flags,
        output instr_ready, rf_rd_addr1, rf_rd_addr2, alu_a, alu_b, alu_shamt,
               alu_control, alu_select, rf_wr_en, rf_wr_addr, rf_wr_data,
               br_taken, br_offset, done, illegal
    );

    modport slave (
        output instr_valid, instr, rf_rd_data1, rf_rd_data2, alu_res, alu_flags,
        input  instr_ready, rf_rd_addr1, rf_rd_addr2, alu_a, alu_b, alu_shamt,
               alu_control, alu_select, rf_wr_en, rf_wr_addr, rf_wr_data,
               br_taken, br_offset, done, illegal
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Four-cycle issue FSM: accept, read operands, execute on the external ALU, then write back
// or resolve a flag-conditional branch. One instruction in flight, no buffering.
module alu_issue_sequencer #(
    parameter logic [5:0] OPC_ALU = 6'b000000,
    parameter logic [5:0] OPC_BR  = 6'b000001
) (
    input logic                   clk,
    input logic                   rst,
    alu_issue_sequencer_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_t;

    state_t      state_q;
    logic        carry_q;
    logic [5:0]  opc_q;
    logic [1:0]  cond_q;
    logic [15:0] lo_q;
    logic        cond_hit;

    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic        sel;
    logic [2:0]  fn;
    logic        is_br;
    logic        unused_lo;

    assign rd        = lo_q[15:11];
    assign shamt     = lo_q[10:6];
    assign sel       = lo_q[3];
    assign fn        = lo_q[2:0];
    assign is_br     = (opc_q == OPC_BR);
    assign unused_lo = ^lo_q[5:4];

    // Flags are sampled from the ALU while rs sits on alu_a; carry comes from the last ALU add.
    always_comb begin
        cond_hit = 1'b0;
        unique case (cond_q)
            2'd0: cond_hit = bus.alu_flags[0];
            2'd1: cond_hit = ~bus.alu_flags[0];
            2'd2: cond_hit = bus.alu_flags[1];
            2'd3: cond_hit = carry_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            carry_q         <= 1'b0;
            opc_q           <= '0;
            cond_q          <= '0;
            lo_q            <= '0;
            bus.instr_ready <= 1'b1;
            bus.rf_rd_addr1 <= '0;
            bus.rf_rd_addr2 <= '0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_shamt   <= '0;
            bus.alu_control <= '0;
            bus.alu_select  <= 1'b0;
            bus.rf_wr_en    <= 1'b0;
            bus.rf_wr_addr  <= '0;
            bus.rf_wr_data  <= '0;
            bus.br_taken    <= 1'b0;
            bus.br_offset   <= '0;
            bus.done        <= 1'b0;
            bus.illegal     <= 1'b0;
        end else begin
            bus.rf_wr_en <= 1'b0;
            bus.br_taken <= 1'b0;
            bus.done     <= 1'b0;
            bus.illegal  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        opc_q           <= bus.instr[31:26];
                        cond_q          <= bus.instr[17:16];
                        lo_q            <= bus.instr[15:0];
                        bus.rf_rd_addr1 <= bus.instr[25:21];
                        bus.rf_rd_addr2 <= bus.instr[20:16];
                        bus.instr_ready <= 1'b0;
                        state_q         <= StRead;
                    end
                end
                StRead: begin
                    // Operands go straight into the ALU drive registers, held until next EXEC.
                    bus.alu_a       <= bus.rf_rd_data1;
                    bus.alu_b       <= bus.rf_rd_data2;
                    bus.alu_shamt   <= shamt;
                    bus.alu_control <= is_br ? 3'b000 : fn;
                    bus.alu_select  <= is_br ? 1'b0 : sel;
                    state_q         <= StExec;
                end
                StExec: begin
                    bus.done <= 1'b1;
                    if (opc_q == OPC_ALU) begin
                        if (fn == 3'b000) begin
                            carry_q <= bus.alu_flags[2];
                        end
                        bus.rf_wr_en   <= (rd != 5'd0);
                        bus.rf_wr_addr <= rd;
                        bus.rf_wr_data <= bus.alu_res;
                    end else if (is_br) begin
                        bus.br_taken  <= cond_hit;
                        bus.br_offset <= lo_q;
                    end else begin
                        bus.illegal <= 1'b1;
                    end
                    state_q <= StWb;
                end
                StWb: begin
                    bus.instr_ready <= 1'b1;
                    state_q         <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer: behavioural register file and ALU around the
// DUT, a vector table driven through a scoreboard, plus reset and throughput sequences.
module tb_alu_issue_sequencer;

    logic clk;
    logic rst;
    alu_issue_sequencer_if bus ();

    alu_issue_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: combinational read of the registered address.
    logic [31:0] regs [32];
    assign bus.rf_rd_data1 = regs[bus.rf_rd_addr1];
    assign bus.rf_rd_data2 = regs[bus.rf_rd_addr2];

    // ALU: 000 add, 001 sub, 010 and, 011 or, 100 sll, others xor.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] sh, input logic [2:0] ctl,
                                              input logic sel_in);
        logic [4:0] amt;
        amt = sel_in ? sh : b[4:0];
        case (ctl)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a << amt;
            default: return a ^ b;
        endcase
    endfunction

    logic [32:0] add_wide;
    assign add_wide      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign bus.alu_res   = alu_model(bus.alu_a, bus.alu_b, bus.alu_shamt, bus.alu_control,
                                     bus.alu_select);
    assign bus.alu_flags = {add_wide[32], bus.alu_a[31], bus.alu_a == 32'd0};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] va;
        logic [31:0] vb;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        br;
        logic [15:0] off;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        br;
        logic [15:0] off;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    function automatic logic [31:0] enc_alu(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [4:0] sh,
                                            input logic sl, input logic [2:0] fn);
        return {6'b000000, rs, rt, rd, sh, 2'b00, sl, fn};
    endfunction

    function automatic logic [31:0] enc_br(input logic [4:0] rs, input logic [1:0] cond,
                                           input logic [15:0] off);
        return {6'b000001, rs, 3'b000, cond, off};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic br, input logic [15:0] off, input logic ill);
        vec_t v;
        v.instr = i; v.va = a; v.vb = b; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.br = br; v.off = off; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_wb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard nonempty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " rf_wr_en"}, 32'(bus.rf_wr_en), 32'(e.wr_en));
        if (e.wr_en) begin
            check({tag, " rf_wr_addr"}, 32'(bus.rf_wr_addr), 32'(e.wr_addr));
            check({tag, " rf_wr_data"}, bus.rf_wr_data, e.wr_data);
        end
        check({tag, " br_taken"}, 32'(bus.br_taken), 32'(e.br));
        if (e.br) check({tag, " br_offset"}, 32'(bus.br_offset), 32'(e.off));
        check({tag, " illegal"}, 32'(bus.illegal), 32'(e.ill));
    endtask

    // Issue one instruction, then follow it to write-back and compare against the scoreboard.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   wait_cnt;
        int   lat;
        regs[v.instr[20:16]] = v.vb;
        regs[v.instr[25:21]] = v.va;
        e.wr_en = v.wr_en; e.wr_addr = v.wr_addr; e.wr_data = v.wr_data;
        e.br = v.br; e.off = v.off; e.ill = v.ill;
        sb.push_back(e);
        bus.instr       = v.instr;
        bus.instr_valid = 1'b1;
        wait_cnt = 0;
        while (!bus.instr_ready && wait_cnt < 8) begin
            step();
            wait_cnt++;
        end
        if (!bus.instr_ready) begin
            check({tag, " ready timeout"}, 32'd0, 32'd1);
            bus.instr_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        step();
        bus.instr_valid = 1'b0;
        check({tag, " rf_rd_addr1"}, 32'(bus.rf_rd_addr1), 32'(v.instr[25:21]));
        lat = 0;
        while (!bus.done && lat < 8) begin
            step();
            lat++;
            if (lat == 1 && v.instr[31:26] == 6'b000001) begin
                check({tag, " br alu_control forced"}, 32'(bus.alu_control), 32'd0);
                check({tag, " br alu_select forced"}, 32'(bus.alu_select), 32'd0);
            end
        end
        check({tag, " latency"}, lat, 32'd2);
        compare_wb(tag);
        step();
        check({tag, " done drops"}, 32'(bus.done), 32'd0);
        check({tag, " ready after wb"}, 32'(bus.instr_ready), 32'd1);
    endtask

    vec_t vecs[14];
    int   accepts;
    int   dones;

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;

        vecs[0]  = mk(enc_alu(5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 3'b000), 32'd5, 32'd7,
                      1'b1, 5'd3, 32'd12, 1'b0, 16'h0, 1'b0);
        vecs[1]  = mk(enc_alu(5'd4, 5'd5, 5'd0, 5'd0, 1'b0, 3'b000), 32'hFFFF_FFFF, 32'd1,
                      1'b0, 5'd0, 32'd0, 1'b0, 16'h0, 1'b0);
        vecs[2]  = mk(enc_br(5'd6, 2'd3, 16'h0010), 32'h55, 32'h55,
                      1'b0, 5'd0, 32'd0, 1'b1, 16'h0010, 1'b0);
        vecs[3]  = mk(enc_alu(5'd1, 5'd2, 5'd6, 5'd4, 1'b1, 3'b100), 32'h1, 32'd2,
                      1'b1, 5'd6, 32'h10, 1'b0, 16'h0, 1'b0);
        vecs[4]  = mk(enc_alu(5'd1, 5'd2, 5'd7, 5'd4, 1'b0, 3'b100), 32'h1, 32'd2,
                      1'b1, 5'd7, 32'h4, 1'b0, 16'h0, 1'b0);
        vecs[5]  = mk(enc_br(5'd8, 2'd2, 16'h012F), 32'h8000_0000, 32'h8000_0000,
                      1'b0, 5'd0, 32'd0, 1'b1, 16'h012F, 1'b0);
        vecs[6]  = mk(enc_br(5'd8, 2'd0, 16'h0040), 32'h8000_0000, 32'h8000_0000,
                      1'b0, 5'd0, 32'd0, 1'b0, 16'h0, 1'b0);
        vecs[7]  = mk(enc_br(5'd8, 2'd1, 16'h0041), 32'h8000_0000, 32'h8000_0000,
                      1'b0, 5'd0, 32'd0, 1'b1, 16'h0041, 1'b0);
        vecs[8]  = mk({6'h3F, 26'h0000123}, 32'd0, 32'd0,
                      1'b0, 5'd0, 32'd0, 1'b0, 16'h0, 1'b1);
        vecs[9]  = mk(enc_alu(5'd9, 5'd10, 5'd11, 5'd0, 1'b0, 3'b001), 32'd10, 32'd3,
                      1'b1, 5'd11, 32'd7, 1'b0, 16'h0, 1'b0);
        vecs[10] = mk(enc_br(5'd12, 2'd3, 16'h0020), 32'd9, 32'd9,
                      1'b0, 5'd0, 32'd0, 1'b1, 16'h0020, 1'b0);
        vecs[11] = mk(enc_alu(5'd13, 5'd14, 5'd15, 5'd0, 1'b0, 3'b000), 32'd1, 32'd1,
                      1'b1, 5'd15, 32'd2, 1'b0, 16'h0, 1'b0);
        vecs[12] = mk(enc_br(5'd12, 2'd3, 16'h0030), 32'd9, 32'd9,
                      1'b0, 5'd0, 32'd0, 1'b0, 16'h0, 1'b0);
        vecs[13] = vecs[1];

        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        step();
        step();
        check("reset instr_ready", 32'(bus.instr_ready), 32'd1);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
        check("reset br_taken", 32'(bus.br_taken), 32'd0);
        check("reset illegal", 32'(bus.illegal), 32'd0);
        check("reset alu_a", bus.alu_a, 32'd0);
        check("reset rf_rd_addr1", 32'(bus.rf_rd_addr1), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while in EXEC drops the instruction and clears carry (set by vec13).
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        bus.instr       = enc_alu(5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 3'b000);
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst-exec instr_ready", 32'(bus.instr_ready), 32'd1);
        check("rst-exec done", 32'(bus.done), 32'd0);
        check("rst-exec rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done || bus.rf_wr_en) dones++;
            step();
        end
        check("rst-exec no late pulse", dones, 32'd0);
        run_vec(mk(enc_br(5'd12, 2'd3, 16'h0050), 32'd9, 32'd9,
                   1'b0, 5'd0, 32'd0, 1'b0, 16'h0, 1'b0), "carry cleared");
        run_vec(mk(enc_alu(5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 3'b000), 32'd20, 32'd22,
                   1'b1, 5'd3, 32'd42, 1'b0, 16'h0, 1'b0), "after rst");

        // instr_valid held high: one accept every four cycles.
        regs[1] = 32'd3;
        regs[2] = 32'd4;
        bus.instr       = enc_alu(5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 3'b000);
        bus.instr_valid = 1'b1;
        accepts = 0;
        dones   = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                dones++;
                compare_wb("tp");
            end
            if (bus.instr_valid && bus.instr_ready) begin
                accepts++;
                sb.push_back('{wr_en: 1'b1, wr_addr: 5'd3, wr_data: 32'd7,
                               br: 1'b0, off: 16'h0, ill: 1'b0});
            end
            step();
        end
        bus.instr_valid = 1'b0;
        check("tp accepts", accepts, 32'd3);
        check("tp dones", dones, 32'd3);
        check("tp scoreboard drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
